writeback_controller: RTL
=========================

Name: writeback_controller

Overview:
- Owns the single write port of the scalar register file (RF) and the single write port of the vector register file (VRF).
- Arbitrates each port between three sources: the scalar-pipeline mem-stage result, the vector-pipeline final-stage result, and a one-entry deferred-vector buffer.
- Consumes the select/buffer controls produced by hazard_detection_unit, which guarantees a conflict-free schedule; this block executes that schedule and flags any contract violation.
- Sits between the mem/vector-final stages and the register files; write-port outputs are registered.

Parameters:
SCALAR_W, 32, RF data width
VECTOR_W, 128, VRF data width
CNT_W, 16, width of the buffered-write event counters

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
stall_mem  input  1  scalar mem stage stalled; scalar requests ignored while high
s_reg_wr_en  input  1  scalar result targets RF
s_vec_wr_en  input  1  scalar result targets VRF
s_wr_reg  input  5  scalar destination register
s_reg_data  input  SCALAR_W  scalar RF data
s_vec_data  input  VECTOR_W  scalar VRF data
v_reg_wr_en  input  1  vector-pipeline result targets RF
v_vec_wr_en  input  1  vector-pipeline result targets VRF
v_wr_reg  input  5  vector-pipeline destination register
v_reg_data  input  SCALAR_W  vector-pipeline RF data
v_vec_data  input  VECTOR_W  vector-pipeline VRF data
buffer_register, buffer_vector  input  1 each  capture the vector result into the RF/VRF buffer this cycle
buffer_register_sel, buffer_vector_sel  input  1 each  drain the RF/VRF buffer to its port this cycle
register_wb_sel, vector_wb_sel  input  1 each  vector result writes the RF/VRF port directly this cycle
rf_wr_en  output  1  RF write strobe
rf_wr_reg  output  5  RF write address
rf_wr_data  output  SCALAR_W  RF write data
vrf_wr_en  output  1  VRF write strobe
vrf_wr_reg  output  5  VRF write address
vrf_wr_data  output  VECTOR_W  VRF write data
err  output  6  sticky errors: [0] RF underflow, [1] RF overflow, [2] RF conflict, [5:3] same order for VRF
buf_cnt_rf, buf_cnt_vrf  output  CNT_W each  saturating count of buffer captures

Behaviour:
- Reset (async, rst high): all outputs 0; buffer valid bits 0; buffer contents 0; counters 0.
- RF and VRF channels are independent and identical, differing only in data width. The rules below are per channel; sreq = s_*_wr_en & ~stall_mem, vreq = v_*_wr_en.
- Capture: cap = buffer & vreq. When cap and the buffer is empty, or is draining in the same cycle, load {v_wr_reg, data} and set valid. The buffer is never granted the port in its capture cycle.
- Port grant priority, evaluated combinationally each cycle:
  1. drain = buffer_sel & valid.
  2. direct = wb_sel & vreq & ~cap.
  3. scalar = sreq.
  4. Otherwise idle.
- Latency: the winning source appears on *_wr_en/_reg/_data exactly 1 cycle later (registered). Idle drives *_wr_en = 0; _reg/_data hold their last value.
- Buffer valid: cleared on drain, unless a capture occurs in the same cycle (new entry loaded, valid stays 1).
- Buffer-then-drain ordering: capture in cycle N, scalar writes from cycle N, drain in cycle N+1. The buffered value therefore lands after the scalar value, which is the required WAW order.
- Error flags, set on the clock edge and held until rst:
  - underflow: buffer_sel & ~valid; no write occurs.
  - overflow: cap while valid & ~drain; the old entry is kept and the new data dropped.
  - conflict: sreq not granted, or direct & drain both requested; the lower-priority source is dropped.
- Counter: increments on each accepted capture; saturates at all-ones with no wrap.
- Register 0 receives no special treatment; address 0 passes through.
- Simultaneous *_sel and wb_sel with the buffer empty: drain is a no-op (underflow), and direct proceeds.
- Reset mid-buffer: the entry is discarded and no write is issued.

Decomposition:
- Shared package: REG_ADDR_W = 5; error-bit index constants (ERR_UNDER, ERR_OVER, ERR_CONF); enum wb_src_e {WB_IDLE, WB_SCALAR, WB_VECTOR, WB_BUFFER} used for the grant mux and the bench monitor.
- Sub-module wb_channel #(DATA_W, CNT_W), instantiated twice (RF, VRF). It holds the buffer, grant logic, output register, error bits and counter. The top level is wiring only.

Test Plan:
- Scalar only: s_reg_wr_en=1, s_wr_reg=5, data=0xDEAD0001, no vector activity -> next cycle rf_wr_en=1, rf_wr_reg=5, rf_wr_data=0xDEAD0001; err=0.
- Vector direct: v_vec_wr_en=1, v_wr_reg=9, vector_wb_sel=1, stall_mem=1 on the scalar side -> next cycle vrf_wr_en=1, vrf_wr_reg=9, data matches; no conflict flag.
- Buffer ordering: cycle N has s_reg_wr_en (reg 3, 0x11), v_reg_wr_en (reg 3, 0x22) and buffer_register=1; cycle N+1 has buffer_register_sel=1 -> RF writes 0x11 at N+1 then 0x22 at N+2; buf_cnt_rf=1.
- Capture and drain in the same cycle: buffer holds reg 4 (0xA); assert buffer_register_sel together with a new capture (reg 6, 0xB) -> 0xA written next cycle; valid stays 1; a later drain writes 0xB.
- Errors: buffer_vector_sel with an empty buffer -> err[3]=1. Second capture without drain -> err[4]=1 and the original entry survives. Unselected sreq -> err[2]=1. All flags stay set until rst.
- Async reset mid-operation: rst pulsed between clock edges while the buffer is valid -> outputs and counters 0 immediately; no write after reset deasserts.

Source files
------------

// File: rtl/writeback_controller_pkg.sv
// writeback_controller_pkg: shared constants and grant-source encoding for the writeback controller
package writeback_controller_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int ERR_UNDER  = 0;
    localparam int ERR_OVER   = 1;
    localparam int ERR_CONF   = 2;
    typedef enum logic [1:0] {WB_IDLE, WB_SCALAR, WB_VECTOR, WB_BUFFER} wb_src_e;
endpackage

// File: rtl/writeback_controller_if.sv
// writeback_controller_if: pipeline-result, schedule-control and register-file write-port bundle
interface writeback_controller_if #(
    parameter int SCALAR_W = 32,
    parameter int VECTOR_W = 128,
    parameter int CNT_W    = 16
);
    localparam int AW = writeback_controller_pkg::REG_ADDR_W;
    logic                stall_mem;
    logic                s_reg_wr_en;
    logic                s_vec_wr_en;
    logic [AW-1:0]       s_wr_reg;
    logic [SCALAR_W-1:0] s_reg_data;
    logic [VECTOR_W-1:0] s_vec_data;
    logic                v_reg_wr_en;
    logic                v_vec_wr_en;
    logic [AW-1:0]       v_wr_reg;
    logic [SCALAR_W-1:0] v_reg_data;
    logic [VECTOR_W-1:0] v_vec_data;
    logic                buffer_register;
    logic                buffer_vector;
    logic                buffer_register_sel;
    logic                buffer_vector_sel;
    logic                register_wb_sel;
    logic                vector_wb_sel;
    logic                rf_wr_en;
    logic [AW-1:0]       rf_wr_reg;
    logic [SCALAR_W-1:0] rf_wr_data;
    logic                vrf_wr_en;
    logic [AW-1:0]       vrf_wr_reg;
    logic [VECTOR_W-1:0] vrf_wr_data;
    logic [5:0]          err;
    logic [CNT_W-1:0]    buf_cnt_rf;
    logic [CNT_W-1:0]    buf_cnt_vrf;

    modport master (
        output stall_mem, s_reg_wr_en, s_vec_wr_en, s_wr_reg, s_reg_data, s_vec_data,
               v_reg_wr_en, v_vec_wr_en, v_wr_reg, v_reg_data, v_vec_data,
               buffer_register, buffer_vector, buffer_register_sel, buffer_vector_sel,
               register_wb_sel, vector_wb_sel,
        input  rf_wr_en, rf_wr_reg, rf_wr_data, vrf_wr_en, vrf_wr_reg, vrf_wr_data,
               err, buf_cnt_rf, buf_cnt_vrf
    );

    modport slave (
        input  stall_mem, s_reg_wr_en, s_vec_wr_en, s_wr_reg, s_reg_data, s_vec_data,
               v_reg_wr_en, v_vec_wr_en, v_wr_reg, v_reg_data, v_vec_data,
               buffer_register, buffer_vector, buffer_register_sel, buffer_vector_sel,
               register_wb_sel, vector_wb_sel,
        output rf_wr_en, rf_wr_reg, rf_wr_data, vrf_wr_en, vrf_wr_reg, vrf_wr_data,
               err, buf_cnt_rf, buf_cnt_vrf
    );
endinterface

// File: rtl/writeback_controller_wb_channel.sv
// wb_channel: one register-file write port with deferred-write buffer, grant mux, error flags and capture counter
module wb_channel
    import writeback_controller_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  s_en,
    input  logic [REG_ADDR_W-1:0] s_reg,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  v_en,
    input  logic [REG_ADDR_W-1:0] v_reg,
    input  logic [DATA_W-1:0]     v_data,
    input  logic                  buf_cap,
    input  logic                  buf_sel,
    input  logic                  wb_sel,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0]     wr_data,
    output logic [2:0]            err,
    output logic [CNT_W-1:0]      cnt
);
    logic                  valid;
    logic [REG_ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0]     b_data;
    logic                  sreq, cap, drain, direct, load;
    logic [2:0]            err_set;
    logic [REG_ADDR_W-1:0] nxt_reg;
    logic [DATA_W-1:0]     nxt_data;
    wb_src_e               src;

    // Grant arbitration: buffer drain beats direct vector beats scalar; a captured vector never writes directly
    always_comb begin
        sreq     = s_en & ~stall;
        cap      = buf_cap & v_en;
        drain    = buf_sel & valid;
        direct   = wb_sel & v_en & ~cap;
        load     = cap & (~valid | drain);
        src      = drain ? WB_BUFFER : direct ? WB_VECTOR : sreq ? WB_SCALAR : WB_IDLE;
        nxt_reg  = src == WB_BUFFER ? b_reg  : src == WB_VECTOR ? v_reg  : s_reg;
        nxt_data = src == WB_BUFFER ? b_data : src == WB_VECTOR ? v_data : s_data;
        err_set            = '0;
        err_set[ERR_UNDER] = buf_sel & ~valid;
        err_set[ERR_OVER]  = cap & valid & ~drain;
        err_set[ERR_CONF]  = (sreq & src != WB_SCALAR) | (direct & drain);
    end

    // One-entry deferred buffer: a capture overrides the drain clear so back-to-back use keeps valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            b_reg  <= '0;
            b_data <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            b_reg  <= v_reg;
            b_data <= v_data;
        end else if (drain) begin
            valid  <= 1'b0;
        end
    end

    // Registered write port; address/data hold across idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= src != WB_IDLE;
            if (src != WB_IDLE) begin
                wr_reg  <= nxt_reg;
                wr_data <= nxt_data;
            end
        end
    end

    // Sticky contract-violation flags and saturating accepted-capture counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= '0;
            cnt <= '0;
        end else begin
            err <= err | err_set;
            if (load && cnt != '1) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/writeback_controller.sv
// writeback_controller: drives the RF and VRF write ports from scalar, vector and buffered results
module writeback_controller #(
    parameter int SCALAR_W = 32,
    parameter int VECTOR_W = 128,
    parameter int CNT_W    = 16
) (
    input logic                   clk,
    input logic                   rst,
    writeback_controller_if.slave bus
);
    logic [2:0] rf_err, vrf_err;

    assign bus.err = {vrf_err, rf_err};

    wb_channel #(.DATA_W(SCALAR_W), .CNT_W(CNT_W)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .stall   (bus.stall_mem),
        .s_en    (bus.s_reg_wr_en),
        .s_reg   (bus.s_wr_reg),
        .s_data  (bus.s_reg_data),
        .v_en    (bus.v_reg_wr_en),
        .v_reg   (bus.v_wr_reg),
        .v_data  (bus.v_reg_data),
        .buf_cap (bus.buffer_register),
        .buf_sel (bus.buffer_register_sel),
        .wb_sel  (bus.register_wb_sel),
        .wr_en   (bus.rf_wr_en),
        .wr_reg  (bus.rf_wr_reg),
        .wr_data (bus.rf_wr_data),
        .err     (rf_err),
        .cnt     (bus.buf_cnt_rf)
    );

    wb_channel #(.DATA_W(VECTOR_W), .CNT_W(CNT_W)) u_vrf (
        .clk     (clk),
        .rst     (rst),
        .stall   (bus.stall_mem),
        .s_en    (bus.s_vec_wr_en),
        .s_reg   (bus.s_wr_reg),
        .s_data  (bus.s_vec_data),
        .v_en    (bus.v_vec_wr_en),
        .v_reg   (bus.v_wr_reg),
        .v_data  (bus.v_vec_data),
        .buf_cap (bus.buffer_vector),
        .buf_sel (bus.buffer_vector_sel),
        .wb_sel  (bus.vector_wb_sel),
        .wr_en   (bus.vrf_wr_en),
        .wr_reg  (bus.vrf_wr_reg),
        .wr_data (bus.vrf_wr_data),
        .err     (vrf_err),
        .cnt     (bus.buf_cnt_vrf)
    );
endmodule
